// File: rtl/led_sched_pkg.sv
// Shared types and sizing helpers for the LED blink scheduler.
package led_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ON   = 3'd1,
    ST_OFF  = 3'd2,
    ST_FIN  = 3'd3,
    ST_GAP  = 3'd4
  } state_e;

  localparam int CNT_W = 4;

  // Width able to hold 0..v-1; never narrower than one bit.
  function automatic int cnt_w(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first set request after the registered pointer, modulo NREQ.
module rr_arbiter #(
  parameter int NREQ  = 4,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req,
  input  logic             update,
  output logic [NREQ-1:0]  gnt_oh,
  output logic [IDX_W-1:0] gnt_idx
);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] cand;
  logic             found;

  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = IDX_W'((int'(ptr_q) + i) % NREQ);
      if (!found && req[cand]) begin
        found         = 1'b1;
        gnt_oh[cand]  = 1'b1;
        gnt_idx       = cand;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (update && found) ptr_d = gnt_idx;
  end

  // Reset pointer to the last requester so requester 0 wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= IDX_W'(NREQ - 1);
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/led_blink_scheduler.sv
// Shares one LED among NREQ requesters: round-robin grant, N blinks per job, enforced off gap.
module led_blink_scheduler
  import led_sched_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int TICK_DIV = 16000,
  parameter int SLOW_MS  = 500,
  parameter int FAST_MS  = 125,
  parameter int GAP_MS   = 1000
) (
  input  logic              CLK,
  input  logic              RESETN,
  input  logic [NREQ-1:0]   REQ,
  input  logic [4*NREQ-1:0] REQ_COUNT,
  input  logic [NREQ-1:0]   REQ_FAST,
  output logic [NREQ-1:0]   GNT,
  output logic              BUSY,
  output logic              DONE,
  output logic [2:0]        DONE_ID,
  output logic              LED
);

  localparam int PRE_W = cnt_w(TICK_DIV);
  localparam int PH_W  = cnt_w(max3(SLOW_MS, FAST_MS, GAP_MS));
  localparam int IDX_W = $clog2(NREQ);

  // Handshake: REQ is a level held until GNT; GNT stays high for the whole
  // job including the FIN cycle, where DONE pulses once with DONE_ID.
  state_e            state_q, state_d;
  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [PH_W-1:0]   ph_q, ph_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic              fast_q, fast_d;
  logic              zero_q, zero_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [IDX_W-1:0]  win_q, win_d;

  logic              timed, tick, ph_end, arb_update;
  logic [PH_W-1:0]   ph_last;
  logic [NREQ-1:0]   arb_oh;
  logic [IDX_W-1:0]  arb_idx;
  logic [CNT_W-1:0]  sel_count;

  rr_arbiter #(.NREQ(NREQ), .IDX_W(IDX_W)) u_arb (
    .clk     (CLK),
    .rst_n   (RESETN),
    .req     (REQ),
    .update  (arb_update),
    .gnt_oh  (arb_oh),
    .gnt_idx (arb_idx)
  );

  assign sel_count = REQ_COUNT[CNT_W*int'(arb_idx) +: CNT_W];
  assign timed     = (state_q == ST_ON) || (state_q == ST_OFF) || (state_q == ST_GAP);
  assign tick      = timed && (pre_q == PRE_W'(TICK_DIV - 1));

  always_comb begin
    ph_last = fast_q ? PH_W'(FAST_MS - 1) : PH_W'(SLOW_MS - 1);
    if (state_q == ST_GAP) ph_last = PH_W'(GAP_MS - 1);
  end

  assign ph_end = tick && (ph_q == ph_last);

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    fast_d     = fast_q;
    zero_d     = zero_q;
    gnt_d      = gnt_q;
    win_d      = win_q;
    arb_update = 1'b0;
    // Prescaler idles at zero outside timed states so every phase starts aligned.
    pre_d      = timed ? (tick ? '0 : pre_q + PRE_W'(1)) : '0;
    ph_d       = tick ? ph_q + PH_W'(1) : ph_q;

    case (state_q)
      ST_IDLE: begin
        ph_d = '0;
        if (|REQ) begin
          arb_update = 1'b1;
          gnt_d      = arb_oh;
          win_d      = arb_idx;
          rem_d      = sel_count;
          fast_d     = REQ_FAST[arb_idx];
          zero_d     = (sel_count == '0);
          state_d    = (sel_count == '0) ? ST_FIN : ST_ON;
        end
      end
      ST_ON: begin
        if (ph_end) begin
          rem_d   = rem_q - CNT_W'(1);
          ph_d    = '0;
          state_d = ST_OFF;
        end
      end
      ST_OFF: begin
        if (ph_end) begin
          ph_d    = '0;
          state_d = (rem_q == '0) ? ST_FIN : ST_ON;
        end
      end
      ST_FIN: begin
        gnt_d   = '0;
        ph_d    = '0;
        state_d = zero_q ? ST_IDLE : ST_GAP;
      end
      ST_GAP: begin
        if (ph_end) begin
          ph_d    = '0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        gnt_d   = '0;
        ph_d    = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q <= ST_IDLE;
      pre_q   <= '0;
      ph_q    <= '0;
      rem_q   <= '0;
      fast_q  <= 1'b0;
      zero_q  <= 1'b0;
      gnt_q   <= '0;
      win_q   <= '0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      ph_q    <= ph_d;
      rem_q   <= rem_d;
      fast_q  <= fast_d;
      zero_q  <= zero_d;
      gnt_q   <= gnt_d;
      win_q   <= win_d;
    end
  end

  // All outputs decode registered state, so async reset clears them at once.
  assign GNT     = gnt_q;
  assign LED     = (state_q == ST_ON);
  assign BUSY    = (state_q != ST_IDLE);
  assign DONE    = (state_q == ST_FIN);
  assign DONE_ID = DONE ? 3'(win_q) : 3'd0;

endmodule

// File: tb/tb_led_blink_scheduler.sv
// Directed bench for led_blink_scheduler with TICK_DIV=4, SLOW_MS=3, FAST_MS=1, GAP_MS=2.
module tb_led_blink_scheduler;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [15:0] req_count;
  logic [3:0]  req_fast;
  logic [3:0]  gnt;
  logic        busy, done, led;
  logic [2:0]  done_id;

  int tests_run    = 0;
  int tests_failed = 0;

  led_blink_scheduler #(
    .NREQ(4), .TICK_DIV(4), .SLOW_MS(3), .FAST_MS(1), .GAP_MS(2)
  ) dut (
    .CLK(clk), .RESETN(rst_n), .REQ(req), .REQ_COUNT(req_count), .REQ_FAST(req_fast),
    .GNT(gnt), .BUSY(busy), .DONE(done), .DONE_ID(done_id), .LED(led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Consecutive cycles (from the current one) where LED equals lvl.
  task automatic run_len(input logic lvl, output int n);
    n = 0;
    while (led === lvl && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s idle_timeout: busy=%b required 0", name, busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = '0; req_count = '0; req_fast = '0;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({led, gnt, busy, done, done_id} !== 10'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: led=%b gnt=%b busy=%b done=%b id=%0d required all 0",
               led, gnt, busy, done, done_id);
    end
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_idle: busy=%b required 0", busy); end
  endtask

  task automatic test_contention();
    int cnt, bad;
    logic [3:0] exp;
    req = 4'hF; req_count = 16'h1111; req_fast = 4'hF;
    for (int j = 0; j < 5; j++) begin
      exp = 4'(1 << (j % 4));
      cnt = 0;
      do begin @(negedge clk); cnt++; end while (gnt === 4'b0 && cnt < 60);
      tests_run++;
      if (gnt !== exp) begin tests_failed++; $display("FAIL rr_grant[%0d]: gnt=%b required %b", j, gnt, exp); end
      if (j > 0) begin
        tests_run++;
        if (cnt !== 10) begin tests_failed++; $display("FAIL rr_gap[%0d]: done_to_grant=%0d required 10", j, cnt); end
      end
      bad = 0; cnt = 0;
      while (done !== 1'b1 && cnt < 60) begin
        if (gnt !== exp) bad++;
        @(negedge clk);
        cnt++;
      end
      tests_run++;
      if (cnt !== 8) begin tests_failed++; $display("FAIL rr_job_len[%0d]: cycles=%0d required 8", j, cnt); end
      tests_run++;
      if (bad !== 0) begin tests_failed++; $display("FAIL rr_gnt_stable[%0d]: bad_cycles=%0d required 0", j, bad); end
      tests_run++;
      if (done_id !== 3'(j % 4)) begin tests_failed++; $display("FAIL rr_done_id[%0d]: id=%0d required %0d", j, done_id, j % 4); end
    end
    req = '0;
    wait_idle("contention");
  endtask

  task automatic test_single_slow();
    int n;
    req = 4'b0001; req_count = 16'h0002; req_fast = 4'b0000;
    @(negedge clk);
    tests_run++;
    if ({gnt, led, busy} !== {4'b0001, 1'b1, 1'b1}) begin
      tests_failed++; $display("FAIL slow_grant: gnt=%b led=%b busy=%b required 0001 1 1", gnt, led, busy);
    end
    // Mid-job input changes and REQ drop must not alter the latched job.
    req = '0; req_count = 16'h0005; req_fast = 4'b0001;
    run_len(1'b1, n);
    tests_run++;
    if (n !== 12) begin tests_failed++; $display("FAIL slow_on1: cycles=%0d required 12", n); end
    run_len(1'b0, n);
    tests_run++;
    if (n !== 12) begin tests_failed++; $display("FAIL slow_off1: cycles=%0d required 12", n); end
    run_len(1'b1, n);
    tests_run++;
    if (n !== 12) begin tests_failed++; $display("FAIL slow_on2: cycles=%0d required 12", n); end
    n = 0;
    while (done !== 1'b1 && n < 100) begin
      if (led !== 1'b0) n = 1000;
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (n !== 12) begin tests_failed++; $display("FAIL slow_off2: cycles_to_done=%0d required 12", n); end
    tests_run++;
    if ({done_id, gnt} !== {3'd0, 4'b0001}) begin
      tests_failed++; $display("FAIL slow_done: id=%0d gnt=%b required 0 0001", done_id, gnt);
    end
    @(negedge clk);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      if (led !== 1'b0 || gnt !== 4'b0) n = 1000;
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (n !== 8) begin tests_failed++; $display("FAIL slow_gap: busy_cycles=%0d required 8", n); end
  endtask

  task automatic test_fast();
    int n;
    req = 4'b0100; req_count = 16'h0300; req_fast = 4'b0100;
    @(negedge clk);
    tests_run++;
    if ({gnt, led} !== {4'b0100, 1'b1}) begin tests_failed++; $display("FAIL fast_grant: gnt=%b led=%b required 0100 1", gnt, led); end
    req = '0;
    for (int p = 0; p < 5; p++) begin
      run_len(p % 2 == 0, n);
      tests_run++;
      if (n !== 4) begin tests_failed++; $display("FAIL fast_phase[%0d]: cycles=%0d required 4", p, n); end
    end
    n = 0;
    while (done !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    tests_run++;
    if (n !== 4) begin tests_failed++; $display("FAIL fast_last_off: cycles_to_done=%0d required 4", n); end
    tests_run++;
    if (done_id !== 3'd2) begin tests_failed++; $display("FAIL fast_done_id: id=%0d required 2", done_id); end
    wait_idle("fast");
  endtask

  task automatic test_rr_skip();
    req = 4'b0101; req_count = 16'h0101; req_fast = 4'b0101;
    @(negedge clk);
    tests_run++;
    if (gnt !== 4'b0001) begin tests_failed++; $display("FAIL rr_skip: gnt=%b required 0001", gnt); end
    req = '0;
    wait_idle("rr_skip");
  endtask

  task automatic test_count15();
    int n, ons;
    logic prev;
    req = 4'b1000; req_count = 16'hF000; req_fast = 4'b1000;
    @(negedge clk);
    req = '0;
    n = 0; ons = 0; prev = 1'b0;
    while (done !== 1'b1 && n < 400) begin
      if (led === 1'b1 && prev === 1'b0) ons++;
      prev = led;
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (ons !== 15) begin tests_failed++; $display("FAIL count15_blinks: blinks=%0d required 15", ons); end
    tests_run++;
    if (n !== 120) begin tests_failed++; $display("FAIL count15_len: cycles=%0d required 120", n); end
    wait_idle("count15");
  endtask

  task automatic test_zero_count();
    req = 4'b0010; req_count = 16'h0000; req_fast = 4'b0000;
    @(negedge clk);
    tests_run++;
    if ({gnt, done, done_id, led} !== {4'b0010, 1'b1, 3'd1, 1'b0}) begin
      tests_failed++; $display("FAIL zero_fin: gnt=%b done=%b id=%0d led=%b required 0010 1 1 0", gnt, done, done_id, led);
    end
    req = 4'b1000; req_count = 16'h1000; req_fast = 4'b1000;
    @(negedge clk);
    tests_run++;
    if ({gnt, busy, done, led} !== 7'd0) begin
      tests_failed++; $display("FAIL zero_no_gap: gnt=%b busy=%b done=%b led=%b required all 0", gnt, busy, done, led);
    end
    @(negedge clk);
    tests_run++;
    if ({gnt, led} !== {4'b1000, 1'b1}) begin tests_failed++; $display("FAIL zero_next_grant: gnt=%b led=%b required 1000 1", gnt, led); end
    req = '0;
    wait_idle("zero_count");
  endtask

  task automatic test_reset_mid_on();
    req = 4'hF; req_count = 16'h1111; req_fast = 4'h0;
    @(negedge clk);
    tests_run++;
    if ({gnt, led} !== {4'b0001, 1'b1}) begin tests_failed++; $display("FAIL midrst_pre: gnt=%b led=%b required 0001 1", gnt, led); end
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({gnt, led, busy} !== 6'd0) begin
      tests_failed++; $display("FAIL midrst_async: gnt=%b led=%b busy=%b required all 0", gnt, led, busy);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (gnt !== 4'b0001) begin tests_failed++; $display("FAIL midrst_ptr: gnt=%b required 0001", gnt); end
    req = '0;
    wait_idle("reset_mid_on");
  endtask

  initial begin
    test_reset();
    test_contention();
    test_single_slow();
    test_fast();
    test_rr_skip();
    test_count15();
    test_zero_count();
    test_reset_mid_on();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
